fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: REQ/VALID/HALT controller feeding decoded fields downstream.
// Optional imem ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_stage #(
  parameter int unsigned PC_W    = 8,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      opcode,
  output logic [2:0]      rs,
  output logic [2:0]      rt,
  output logic [2:0]      rd,
  output logic [2:0]      funct,
  output logic [5:0]      imm,
  output logic [PC_W-1:0] out_pc,
  output logic            halted,
  output logic            fetch_error
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            fetch_error_q, fetch_error_d;
  logic            timeout_s;
  logic            fetch_done_s;

  assign fetch_done_s = (state_q == ST_REQ) && imem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned   CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait counter: runs only while stuck in REQ, restarts on any state change or redirect
  always_comb begin
    cnt_d = '0;
    if (!redirect_valid && (state_q == ST_REQ) && !imem_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = (state_q == ST_REQ) && !imem_ack && (cnt_q == CNT_LAST);
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = TIMEOUT;
  assign timeout_s        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect overrides every other event
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_ack) begin
            state_d = ST_VALID;
          end else if (timeout_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            state_d = (ir_q[15:12] == HALT_OP) ? ST_HALT : ST_REQ;
          end else begin
            state_d = ST_VALID;
          end
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_REQ;
      endcase
    end
  end

  // Output decode from state only
  always_comb begin
    imem_req  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_REQ:   imem_req  = 1'b1;
      ST_VALID: out_valid = 1'b1;
      ST_HALT:  halted    = 1'b1;
      default:  imem_req  = 1'b0;
    endcase
  end

  // Datapath next-state: an ack coinciding with a redirect is dropped
  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    out_pc_d      = out_pc_q;
    fetch_error_d = fetch_error_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (fetch_done_s) begin
      ir_d     = imem_rdata;
      out_pc_d = pc_q;
      pc_d     = pc_q + PC_W'(1);
    end else if (timeout_s) begin
      fetch_error_d = 1'b1;
    end else begin
      pc_d = pc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= '0;
      ir_q          <= 16'h0000;
      out_pc_q      <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      out_pc_q      <= out_pc_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_pc      = out_pc_q;
  assign fetch_error = fetch_error_q;
  assign opcode      = ir_q[15:12];
  assign rs          = ir_q[11:9];
  assign rt          = ir_q[8:6];
  assign rd          = ir_q[5:3];
  assign funct       = ir_q[2:0];
  assign imm         = ir_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// compared each cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [2:0]  rs, rt, rd, funct;
  logic [5:0]  imm;
  logic [7:0]  out_pc;
  logic        halted;
  logic        fetch_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .funct          (funct),
    .imm            (imm),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_error    (fetch_error)
  );

  // Reference model: what is being fetched, what is held for downstream, whether stopped
  logic [7:0]  m_pc, m_out_pc;
  logic [15:0] m_ir;
  logic        m_pres, m_stop, m_err;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_out_pc = 8'h00; m_ir = 16'h0000;
    m_pres = 1'b0; m_stop = 1'b0; m_err = 1'b0; m_wait = 0;
  endtask

  task automatic model_update(input logic ack, input logic [15:0] rdat, input logic rv,
                              input logic [7:0] rpc, input logic rdy);
    if (rv) begin
      m_pc = rpc; m_pres = 1'b0; m_stop = 1'b0; m_wait = 0;
    end else if (m_stop) begin
      m_wait = 0;
    end else if (m_pres) begin
      if (rdy) begin
        m_pres = 1'b0;
        if (m_ir[15:12] == 4'hF) m_stop = 1'b1;
      end
    end else if (ack) begin
      m_ir = rdat; m_out_pc = m_pc; m_pc = m_pc + 8'd1; m_pres = 1'b1; m_wait = 0;
    end else begin
      m_wait++;
`ifdef FETCH_TIMEOUT_EN
      if (m_wait == TMO) begin
        m_stop = 1'b1; m_err = 1'b1; m_wait = 0;
      end
`endif
    end
  endtask

  task automatic check_all();
    logic e_req;
    e_req = !m_pres && !m_stop;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(m_pres));
    if (m_pres) begin
      chk("out_pc", 32'(out_pc), 32'(m_out_pc));
      chk("fields", {16'h0, opcode, rs, rt, rd, funct},
          {16'h0, m_ir[15:12], m_ir[11:9], m_ir[8:6], m_ir[5:3], m_ir[2:0]});
      chk("imm", 32'(imm), 32'(m_ir[5:0]));
    end
    chk("halted", 32'(halted), 32'(m_stop));
    chk("fetch_error", 32'(fetch_error), 32'(m_err));
  endtask

  task automatic step(input logic ack, input logic [15:0] rdat, input logic rv,
                      input logic [7:0] rpc, input logic rdy);
    imem_ack = ack; imem_rdata = rdat; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    model_update(ack, rdat, rv, rpc, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
    redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_out_pc", 32'(out_pc), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    reset = 1'b0;

    // Back-to-back fetches of 16'h1234 with downstream always ready
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1);
      if (i == 0) begin
        chk("op31_opcode", 32'(opcode), 32'h1);
        chk("op31_rs", 32'(rs), 32'h1);
        chk("op31_rt", 32'(rt), 32'h0);
        chk("op31_rd", 32'(rd), 32'h6);
        chk("op31_funct", 32'(funct), 32'h4);
        chk("op31_out_pc", 32'(out_pc), 32'h0);
      end
    end
    chk("op31_addr", 32'(imem_addr), 32'h3);

    // Downstream stall: held instruction stays put, no new request
    step(1'b1, 16'h5A5A, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'hAAAA, 1'b0, 8'h00, 1'b0);
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_out_pc", 32'(out_pc), 32'h3);
    end
    step(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    chk("stall_addr", 32'(imem_addr), 32'h4);

    // PC wrap at 8'hFF
    step(1'b0, 16'h0000, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 16'h2000, 1'b0, 8'h00, 1'b0);
    chk("wrap_out_pc", 32'(out_pc), 32'hFF);
    step(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    chk("wrap_addr", 32'(imem_addr), 32'h00);

    // HALT instruction, then redirect out of HALT
    step(1'b1, 16'hF000, 1'b0, 8'h00, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    chk("halt_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i), 1'b0, 8'h00, 1'b1);
    chk("halt_req", 32'(imem_req), 32'h0);
    step(1'b0, 16'h0000, 1'b1, 8'h20, 1'b0);
    chk("halt_exit_addr", 32'(imem_addr), 32'h20);
    chk("halt_exit_halted", 32'(halted), 32'h0);

    // Redirect coinciding with ack drops the data
    step(1'b1, 16'h1111, 1'b1, 8'h40, 1'b1);
    chk("redir_valid", 32'(out_valid), 32'h0);
    chk("redir_addr", 32'(imem_addr), 32'h40);

    // Memory never acks
    for (int i = 0; i < TMO; i++) step(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
`ifdef FETCH_TIMEOUT_EN
    chk("tmo_error", 32'(fetch_error), 32'h1);
    chk("tmo_halted", 32'(halted), 32'h1);
`else
    chk("tmo_req", 32'(imem_req), 32'h1);
    chk("tmo_error", 32'(fetch_error), 32'h0);
`endif
    step(1'b0, 16'h0000, 1'b1, 8'h10, 1'b0);

    // Reset in the middle of a fetch with an ack present
    imem_ack = 1'b1; imem_rdata = 16'h7777; reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_addr", 32'(imem_addr), 32'h0);
    chk("mid_rst_error", 32'(fetch_error), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid2", 32'(out_valid), 32'h0);
    reset = 1'b0; imem_ack = 1'b0;
    model_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) == 0),
           8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
